// File: rtl/stopwatch_control_pkg.sv
// Shared definitions for the stopwatch controller: FSM states, time-field widths and limits.
// Optional lap capture is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_control_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam int MS_MAX  = 999;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [MS_W-1:0]  ms;
        logic [SEC_W-1:0] sec;
        logic [MIN_W-1:0] min;
        logic [HR_W-1:0]  hr;
    } sw_time_t;

    function automatic logic ms_last(input logic [MS_W-1:0] v);
        return v == MS_W'(MS_MAX);
    endfunction

    function automatic logic sec_last(input logic [SEC_W-1:0] v);
        return v == SEC_W'(SEC_MAX);
    endfunction

    function automatic logic min_last(input logic [MIN_W-1:0] v);
        return v == MIN_W'(MIN_MAX);
    endfunction

    function automatic logic hr_last(input logic [HR_W-1:0] v);
        return v == HR_W'(HR_MAX);
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides the system clock down to a 1 ms tick; counts only while enabled, holds otherwise.
module ms_prescaler #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch sequencer: button press detection, IDLE/RUN/PAUSE FSM, ms-tick cascade and lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise lap outputs read 0.
module stopwatch_control
    import stopwatch_control_pkg::*;
#(
    parameter int CLK_PER_MS = 50000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_stop,
    input  logic             i_lap_reset,
    input  logic [MS_W-1:0]  i_ms,
    input  logic [SEC_W-1:0] i_sec,
    input  logic [MIN_W-1:0] i_min,
    input  logic [HR_W-1:0]  i_hr,
    output logic             o_ms_up,
    output logic             o_sec_up,
    output logic             o_min_up,
    output logic             o_hr_up,
    output logic             o_clr,
    output logic             o_running,
    output logic             o_overflow,
    output logic             o_lap_valid,
    output logic [MS_W-1:0]  o_lap_ms,
    output logic [SEC_W-1:0] o_lap_sec,
    output logic [MIN_W-1:0] o_lap_min,
    output logic [HR_W-1:0]  o_lap_hr
);

    sw_state_e state, next_state;

    logic ss_prev, lr_prev;
    logic ss_press, lap_press;
    logic clr_evt, presc_clr, presc_en, tick;
    logic c_ms, c_sec, c_min, c_hr;

    // start_stop has priority: a simultaneous lap_reset press is dropped
    assign ss_press  = i_start_stop && !ss_prev;
    assign lap_press = i_lap_reset && !lr_prev && !ss_press;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ss_prev <= 1'b0;
            lr_prev <= 1'b0;
        end else begin
            ss_prev <= i_start_stop;
            lr_prev <= i_lap_reset;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ss_press) next_state = RUN;
            RUN:     if (ss_press) next_state = PAUSE;
            PAUSE: begin
                if (ss_press)       next_state = RUN;
                else if (lap_press) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Prescaler freezes on the pause edge so resume continues from the held count
    always_comb begin
        o_running = (state == RUN);
        clr_evt   = lap_press && (state == IDLE || state == PAUSE);
        presc_clr = clr_evt || (state == IDLE && ss_press);
        presc_en  = (state == RUN) && (next_state == RUN);
    end

    ms_prescaler #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_presc (
        .clk  (i_clk),
        .rst  (i_rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    assign c_ms  = tick;
    assign c_sec = c_ms  && ms_last(i_ms);
    assign c_min = c_sec && sec_last(i_sec);
    assign c_hr  = c_min && min_last(i_min);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ms_up    <= 1'b0;
            o_sec_up   <= 1'b0;
            o_min_up   <= 1'b0;
            o_hr_up    <= 1'b0;
            o_clr      <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_ms_up  <= c_ms;
            o_sec_up <= c_sec;
            o_min_up <= c_min;
            o_hr_up  <= c_hr;
            o_clr    <= clr_evt;
            if (clr_evt)                    o_overflow <= 1'b0;
            else if (c_hr && hr_last(i_hr)) o_overflow <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic     lap_evt;
    sw_time_t lap_q;

    assign lap_evt = lap_press && (state == RUN);

    // First lap press captures, second releases the display while keeping the value
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lap_q       <= '0;
            o_lap_valid <= 1'b0;
        end else if (clr_evt) begin
            lap_q       <= '0;
            o_lap_valid <= 1'b0;
        end else if (lap_evt) begin
            if (!o_lap_valid) begin
                lap_q       <= '{ms: i_ms, sec: i_sec, min: i_min, hr: i_hr};
                o_lap_valid <= 1'b1;
            end else begin
                o_lap_valid <= 1'b0;
            end
        end
    end

    assign o_lap_ms  = lap_q.ms;
    assign o_lap_sec = lap_q.sec;
    assign o_lap_min = lap_q.min;
    assign o_lap_hr  = lap_q.hr;
`else
    assign o_lap_valid = 1'b0;
    assign o_lap_ms    = '0;
    assign o_lap_sec   = '0;
    assign o_lap_min   = '0;
    assign o_lap_hr    = '0;
`endif

endmodule
